// File: rtl/map_pkg.sv
// -----------------------------------------------------------------------------
// map_pkg
// Shared definitions for the writable map store:
//   - default grid geometry and cell codes
//   - init sequencer state type
//   - is_edge() helper used to classify outer-wall cells
// -----------------------------------------------------------------------------
package map_pkg;

    localparam int         DEF_COLBITS    = 4;
    localparam int         DEF_ROWBITS    = 4;
    localparam int         DEF_BITS       = 2;
    localparam logic [1:0] DEF_BORDER_VAL = 2'b11;
    localparam logic [1:0] DEF_FILL_VAL   = 2'b00;

    typedef enum logic {
        INIT,
        IDLE
    } map_state_t;

    // True when (row, col) lies on the outer edge of a max_row x max_col grid.
    function automatic logic is_edge(input int row, input int col,
                                     input int max_row, input int max_col);
        return (row == 0) || (row == max_row) || (col == 0) || (col == max_col);
    endfunction

endpackage

// File: rtl/map_init_seq.sv
// -----------------------------------------------------------------------------
// map_init_seq
// Init sweep sequencer: walks every stored cell once after reset or after a
// clear_req seen in IDLE, emitting one write per cycle.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   clear_req      restart the sweep (ignored while a sweep is running)
//   init_busy      registered, high for the whole sweep
//   init_we        write strobe for the sweep write
//   init_addr      linear address of the cell being written
//   init_data      code for that cell (wall on edges unless HARD_BORDER)
// -----------------------------------------------------------------------------
module map_init_seq
    import map_pkg::*;
#(
    parameter int              COLBITS     = DEF_COLBITS,
    parameter int              ROWBITS     = DEF_ROWBITS,
    parameter int              BITS        = DEF_BITS,
    parameter int              DEPTH       = 1 << (COLBITS + ROWBITS),
    parameter bit              HARD_BORDER = 1'b0,
    parameter logic [BITS-1:0] BORDER_VAL  = DEF_BORDER_VAL,
    parameter logic [BITS-1:0] FILL_VAL    = DEF_FILL_VAL
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_req,
    output logic                       init_busy,
    output logic                       init_we,
    output logic [COLBITS+ROWBITS-1:0] init_addr,
    output logic [BITS-1:0]            init_data
);

    localparam int AW = COLBITS + ROWBITS;
    // One spare bit so the terminal compare can never alias a wrapped count.
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    map_state_t     state;
    logic [CW-1:0]  cnt;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            cnt       <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    if (cnt == LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        init_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state     <= INIT;
                        cnt       <= '0;
                        init_busy <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign init_we   = (state == INIT);
    assign init_addr = cnt[AW-1:0];

    // With a hard border only the interior is stored, so every swept cell is
    // interior; otherwise the counter is {row, col} and edges get the wall code.
    assign init_data = (!HARD_BORDER &&
                        is_edge(int'(cnt[AW-1:COLBITS]), int'(cnt[COLBITS-1:0]),
                                (1 << ROWBITS) - 1, (1 << COLBITS) - 1))
                       ? BORDER_VAL : FILL_VAL;

endmodule

// File: rtl/map_ram.sv
// -----------------------------------------------------------------------------
// map_ram
// Writable 2^COLBITS x 2^ROWBITS map of BITS-wide cell codes with a registered
// read port (tracer side) and a write port (host side). An internal sweep
// fills the grid with an outer-wall box on reset or on clear_req.
//
// Optional build macro: MAP_HARD_BORDER_EN
//   defined   - only interior cells are stored; edge reads return BORDER_VAL,
//               edge writes are dropped, the sweep covers the interior only.
//   undefined - the full grid is stored and every cell is writable.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   clear_req                  re-run the init sweep (honoured only when idle)
//   init_busy                  high while the sweep runs
//   rd_req, rd_col, rd_row     read request and cell coordinates
//   rd_valid, rd_val           1-cycle pulse and registered data (latency 1)
//   wr_en, wr_col, wr_row,
//   wr_val                     host write strobe, coordinates and data
//   wr_ready                   writes accepted (= ~init_busy)
// -----------------------------------------------------------------------------
module map_ram
    import map_pkg::*;
#(
    parameter int              COLBITS    = DEF_COLBITS,
    parameter int              ROWBITS    = DEF_ROWBITS,
    parameter int              BITS       = DEF_BITS,
    parameter logic [BITS-1:0] BORDER_VAL = DEF_BORDER_VAL,
    parameter logic [BITS-1:0] FILL_VAL   = DEF_FILL_VAL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_req,
    output logic               init_busy,
    input  logic               rd_req,
    input  logic [COLBITS-1:0] rd_col,
    input  logic [ROWBITS-1:0] rd_row,
    output logic               rd_valid,
    output logic [BITS-1:0]    rd_val,
    input  logic               wr_en,
    input  logic [COLBITS-1:0] wr_col,
    input  logic [ROWBITS-1:0] wr_row,
    input  logic [BITS-1:0]    wr_val,
    output logic               wr_ready
);

    localparam int AW      = COLBITS + ROWBITS;
    localparam int MAX_COL = (1 << COLBITS) - 1;
    localparam int MAX_ROW = (1 << ROWBITS) - 1;
    localparam int SCOLS   = (1 << COLBITS) - 2;   // stored columns, hard border
`ifdef MAP_HARD_BORDER_EN
    localparam bit HARD    = 1'b1;
    localparam int DEPTH   = ((1 << COLBITS) - 2) * ((1 << ROWBITS) - 2);
`else
    localparam bit HARD    = 1'b0;
    localparam int DEPTH   = 1 << AW;
`endif

    // Grid coordinates to storage index. With a hard border the interior is
    // packed row-major after shifting both axes down by one.
    function automatic logic [AW-1:0] cell_addr(input logic [ROWBITS-1:0] r,
                                                input logic [COLBITS-1:0] c);
        logic [AW-1:0] r_i;
        logic [AW-1:0] c_i;
        if (!HARD) return {r, c};
        r_i = AW'(r) - AW'(1);
        c_i = AW'(c) - AW'(1);
        return (r_i * AW'(SCOLS)) + c_i;
    endfunction

    logic [BITS-1:0] mem [DEPTH];

    logic            init_we;
    logic [AW-1:0]   init_addr;
    logic [BITS-1:0] init_data;

    map_init_seq #(
        .COLBITS     (COLBITS),
        .ROWBITS     (ROWBITS),
        .BITS        (BITS),
        .DEPTH       (DEPTH),
        .HARD_BORDER (HARD),
        .BORDER_VAL  (BORDER_VAL),
        .FILL_VAL    (FILL_VAL)
    ) u_init_seq (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .init_busy (init_busy),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic          rd_edge;
    logic          wr_edge;
    logic          host_we;
    logic          rd_accept;

    assign wr_ready  = ~init_busy;
    assign rd_addr   = cell_addr(rd_row, rd_col);
    assign wr_addr   = cell_addr(wr_row, wr_col);
    assign rd_edge   = HARD && is_edge(int'(rd_row), int'(rd_col), MAX_ROW, MAX_COL);
    assign wr_edge   = HARD && is_edge(int'(wr_row), int'(wr_col), MAX_ROW, MAX_COL);
    assign host_we   = wr_en && wr_ready && !wr_edge;
    assign rd_accept = rd_req && !init_busy;

    // The sweep owns the array while busy; host writes are already gated off
    // by wr_ready then, so the mux never drops a committed host write.
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [BITS-1:0] mem_data;

    assign mem_we   = init_we || host_we;
    assign mem_addr = init_we ? init_addr : wr_addr;
    assign mem_data = init_we ? init_data : wr_val;

    // NOTE: the array has no reset; the init sweep defines every stored cell
    // before the first read can be accepted, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_val   <= '0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                if (rd_edge) begin
                    rd_val <= BORDER_VAL;
                end else if (host_we && (wr_addr == rd_addr)) begin
                    rd_val <= wr_val;      // write-first on a same-cell collision
                end else begin
                    rd_val <= mem[rd_addr];
                end
            end
        end
    end

endmodule

// File: doc/map_ram.md
Name: map_ram

Overview:
- Writable, parametrised successor to the static map store. Holds a 2^COLBITS x 2^ROWBITS grid of BITS-wide cell codes.
- Has a registered read port for the tracer and a write port for host/game updates.
- A built-in init sequencer fills the grid with an outer-wall box on reset or on request.
- Sits between the tracer (reader) and the host/SPI register block (writer).

Parameters:
- COLBITS, 4, log2 of grid columns
- ROWBITS, 4, log2 of grid rows
- BITS, 2, bits per cell
- BORDER_VAL, 2'b11, cell code written to outer-edge cells by init (width BITS)
- FILL_VAL, 2'b00, cell code written to interior cells by init (width BITS)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear_req  in  1  pulse: re-run init sweep (honoured only in IDLE)
- init_busy  out  1  high while init sweep in progress
- rd_req  in  1  read request
- rd_col  in  COLBITS  read column
- rd_row  in  ROWBITS  read row
- rd_valid  out  1  one-cycle pulse: rd_val updated
- rd_val  out  BITS  registered read data
- wr_en  in  1  write strobe
- wr_col  in  COLBITS  write column
- wr_row  in  ROWBITS  write row
- wr_val  in  BITS  write data
- wr_ready  out  1  high when writes are accepted (= ~init_busy)

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: init_busy=1, wr_ready=0, rd_valid=0, rd_val=0. The state machine enters INIT with sweep counter=0.
- States: INIT, IDLE.
  - INIT: each cycle writes the cell at counter {row,col} (col = LSBs). The cell gets BORDER_VAL if row==0, row==MAXROW, col==0 or col==MAXCOL; otherwise FILL_VAL. The counter increments by one.
  - INIT exits after the last cell (counter == 2^(COLBITS+ROWBITS)-1). Exactly 2^(COLBITS+ROWBITS) cycles: 256 at defaults.
  - IDLE -> INIT on clear_req. The counter is zeroed. init_busy rises the cycle after clear_req.
  - clear_req in INIT: ignored; the sweep does not restart.
  - reset asserted mid-sweep: the sweep restarts from counter 0 on the next cycle.
- Read port:
  - Request accepted only when rd_req && !init_busy. Requests during INIT are dropped; rd_valid stays 0.
  - Latency 1: rd_val and rd_valid update the cycle after acceptance.
  - rd_valid is a 1-cycle pulse per accepted request. rd_val holds its value until the next accepted read.
  - Back-to-back requests are accepted every cycle (throughput 1/cycle).
- Write port:
  - Write committed only when wr_en && wr_ready. wr_en during INIT is dropped with no effect.
- Read/write same cell, same cycle: write-first. rd_val returns wr_val.
- Read/write different cells, same cycle: both complete.
- Arithmetic: the sweep counter is COLBITS+ROWBITS+1 bits wide, so the terminal compare has no wrap ambiguity. All addresses are in range by construction (power-of-two depth).

Optional Feature:
- MAP_HARD_BORDER_EN defined:
  - Only the interior (2^COLBITS-2) x (2^ROWBITS-2) cells are stored; the address is offset by -1 on each axis.
  - Reads of edge cells return BORDER_VAL combinationally into the rd_val register, with the same latency and rd_valid.
  - Writes to edge cells are silently dropped.
  - Init sweeps the interior only: (2^COLBITS-2)*(2^ROWBITS-2) cycles (196 at defaults).
  - Same-cell write-first bypass applies to interior cells only.
- Undefined: full grid stored; edge cells are writable.

Decomposition:
- Package map_pkg: default COLBITS/ROWBITS/BITS, BORDER_VAL/FILL_VAL defaults, state enum {INIT, IDLE}, an is_edge(row,col) function.
- Sub-module map_init_seq: sweep counter, INIT/IDLE FSM, clear_req handling. Outputs init_busy plus the init write address/data/strobe.
- map_ram muxes the init write and the host write (init wins; the host is gated by wr_ready).

Test Plan:
- Reset, then count cycles until init_busy==0 -> exactly 256 (defaults; 196 with MAP_HARD_BORDER_EN). Then read (0,5) -> 3, (15,9) -> 3, (7,7) -> 0. rd_valid pulses once per read, 1 cycle after rd_req.
- Write (col 4, row 6)=2, then read it next cycle -> rd_val=2. In the same cycle, read (4,6) with wr_val=1 to (4,6) -> rd_val=1 (write-first).
- Issue rd_req and wr_en during INIT -> rd_valid stays 0 and no write lands. After init, (3,3) reads 0.
- After writing interior cells, pulse clear_req -> init_busy high for 256 cycles, then all written cells read back FILL_VAL. A clear_req mid-sweep does not extend the count.
- Assert reset at sweep cycle 100 -> sweep restarts, init_busy drops exactly 256 cycles after reset deasserts.
- Streaming reads to 16 consecutive addresses, one per cycle -> 16 rd_valid pulses on consecutive cycles with correct data. With MAP_HARD_BORDER_EN, a write of 0 to (0,0) is dropped and the read returns 3.
